mmio_input_port: RTL
====================

Name: mmio_input_port

Overview:
- Board-input side of the processor's I/O path: the complement of the display output path.
- Synchronises and debounces the pushbuttons and slide switches, and detects button presses.
- Exposes levels, sticky press events and a press counter to the processor as memory-mapped registers with a registered read port.
- Sits beside the data memory; the address decoder qualifies rd_en/wr_en with the hit output.

Parameters:
N_BTN, 5, number of pushbutton inputs (1..16)
N_SW, 16, number of slide-switch inputs (1..16)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a level is accepted (10 ms at 100 MHz; benches use 4)
BASE_ADDR, 32'hFFFF_FF00, byte address of register 0; must be 32-byte aligned

Ports:
CLK100MHZ  input  1  system clock, the only clock
reset  input  1  synchronous, active-high reset
btn_raw  input  N_BTN  asynchronous pushbutton pins, 1 = pressed
sw_raw  input  N_SW  asynchronous switch pins
addr  input  32  processor data address (dataaddr)
rd_en  input  1  read strobe, one cycle per access
wr_en  input  1  write strobe (memwrite qualified)
wdata  input  32  write data
hit  output  1  combinational: addr[31:5] == BASE_ADDR[31:5]
rdata  output  32  registered read data
rdata_valid  output  1  high exactly one cycle after an accepted read
irq  output  1  interrupt request (see Optional Feature)

Behaviour:
- Clock and reset: reset is synchronous, active-high, sampled on the CLK100MHZ rising edge. Applies mid-operation identically to power-up.
- Reset values: rdata=0, rdata_valid=0, irq=0. All stable levels=0, events=0, count=0, debounce counters=0, synchroniser flops=0.
- Synchroniser: each raw input passes through a 2-flop synchroniser; sync = output of the second flop.
- Debounce, per input:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from raw edge to stable change is DEBOUNCE_CYCLES+2 cycles.
- Press detect: press[i] = stable_btn[i] & ~stable_btn_d[i], a one-cycle pulse. Releases generate no event.
- Register map, offset = addr[4:0]; reads are zero-extended:
  - 0x00 SW: stable switch levels.
  - 0x04 BTN: stable button levels.
  - 0x08 EVENTS: sticky press flags, clear-on-read.
  - 0x0C COUNT: 32-bit total presses, wraps 0xFFFFFFFF -> 0.
  - 0x10 IRQMASK: present only with the optional feature.
  - Other offsets read 0.
- Read handshake: an access is accepted when rd_en & hit. On the next cycle rdata holds the register value sampled at acceptance and rdata_valid=1. Otherwise rdata_valid=0 and rdata holds its last value. Back-to-back reads are allowed every cycle.
- EVENTS update each cycle: events <= (events & ~clr) | press, where clr = all ones on an accepted read of 0x08.
  - Set beats clear: a press in the same cycle as the clearing read is retained and reported by the next read.
- COUNT update: count <= count + popcount(press). Simultaneous presses on several buttons in one cycle all count.
- Writes: wr_en & hit at any offset other than 0x10 is ignored. EVENTS and COUNT are not writable.
- rd_en and wr_en high together: the read is serviced and the write is applied; the read returns the pre-write value.

Optional Feature:
- Macro MMIO_INPUT_IRQ_EN.
- Defined:
  - Adds register IRQMASK, width N_BTN, reset 0, written by wr_en & hit at offset 0x10 from wdata[N_BTN-1:0], readable at 0x10.
  - irq is registered: irq <= |(events_next & irqmask). It asserts the cycle after the event flag is set and drops the cycle after a clearing read removes it.
- Not defined: no IRQMASK storage, offset 0x10 reads 0, writes are ignored, irq tied to 0.

Decomposition:
- Shared package mmio_pkg:
  - Offset constants OFS_SW=5'h00, OFS_BTN=5'h04, OFS_EVENTS=5'h08, OFS_COUNT=5'h0C, OFS_IRQMASK=5'h10.
  - Default BASE_ADDR constant.
- One sub-module debounce_cell: a single-bit synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES, output stable. It is instantiated N_BTN+N_SW times with generate.

Test Plan:
1. DEBOUNCE_CYCLES=4. Drive btn_raw[0] high for 3 cycles, then low -> BTN reads 0, EVENTS reads 0, COUNT reads 0.
2. Hold btn_raw[0] high for 10 cycles -> BTN bit0 goes to 1 six cycles after the edge. First EVENTS read returns 0x1, second returns 0x0, COUNT returns 1.
3. Stable-press btn_raw[1] and btn_raw[3] in the same cycle -> EVENTS=0x0A, COUNT increments by 2.
4. Time a btn_raw[2] press so its press pulse coincides with an accepted EVENTS read -> that read returns the old flags without bit2; the next read returns 0x4.
5. With MMIO_INPUT_IRQ_EN defined, write IRQMASK=0x1 and press btn 0 -> irq=1 one cycle after the flag sets. After an EVENTS read, irq=0. Without the macro, irq stays 0 and IRQMASK reads 0.
6. sw_raw=16'hA5A5 for 10 cycles, then assert reset for 1 cycle while a read is in flight -> rdata_valid=0 and all registers read 0. SW then reads 0xA5A5 once the debounce period has elapsed again.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped board-input port:
// register offsets, default base address and a popcount helper.
package mmio_pkg;

    localparam logic [4:0]  OFS_SW            = 5'h00;
    localparam logic [4:0]  OFS_BTN           = 5'h04;
    localparam logic [4:0]  OFS_EVENTS        = 5'h08;
    localparam logic [4:0]  OFS_COUNT         = 5'h0C;
    localparam logic [4:0]  OFS_IRQMASK       = 5'h10;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

    // Number of set bits in a 16-bit vector (used to count simultaneous presses).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mmio_input_port_debounce_cell.sv
// Single-bit input conditioner: two-flop synchroniser followed by a
// debounce counter that only accepts a new level after DEBOUNCE_CYCLES
// consecutive cycles of disagreement with the current stable level.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, run the debounce counter.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped board-input port: debounced switch/button levels, sticky
// clear-on-read press events and a running press counter, read through a
// registered one-cycle-latency read port.
// Optional interrupt mask register and irq output: define MMIO_INPUT_IRQ_EN.
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter int          N_BTN           = 5,
    parameter int          N_SW            = 16,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       wdata,
    output logic              hit,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              irq
);

    logic [N_BTN-1:0] btn_stable;
    logic [N_SW-1:0]  sw_stable;

    genvar gi;
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk    (CLK100MHZ),
            .reset  (reset),
            .raw    (btn_raw[gi]),
            .stable (btn_stable[gi])
        );
    end
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk    (CLK100MHZ),
            .reset  (reset),
            .raw    (sw_raw[gi]),
            .stable (sw_stable[gi])
        );
    end

    assign hit = (addr[31:5] == BASE_ADDR[31:5]);

    logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0] events_q, events_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] clr;
    logic [4:0]       ofs;
    logic             accept;
    logic [31:0]      rmux;

`ifdef MMIO_INPUT_IRQ_EN
    logic [N_BTN-1:0] irqmask_q, irqmask_d;
    logic             irq_q, irq_d;
`endif

    // Wdata bits above the mask width are never stored.
    logic unused_s;
    assign unused_s = ^{wdata, wr_en};

    // Press detection, event/counter update and the read-data mux.
    always_comb begin
        ofs        = addr[4:0];
        accept     = rd_en & hit;
        btn_prev_d = btn_stable;
        press      = btn_stable & ~btn_prev_q;
        if (accept && (ofs == OFS_EVENTS)) begin
            clr = '1;
        end else begin
            clr = '0;
        end
        // A press arriving with the clearing read survives (set beats clear).
        events_d = (events_q & ~clr) | press;
        count_d  = count_q + 32'(popcount16(16'(press)));

        case (ofs)
            OFS_SW:      rmux = 32'(sw_stable);
            OFS_BTN:     rmux = 32'(btn_stable);
            OFS_EVENTS:  rmux = 32'(events_q);
            OFS_COUNT:   rmux = count_q;
`ifdef MMIO_INPUT_IRQ_EN
            OFS_IRQMASK: rmux = 32'(irqmask_q);
`endif
            default:     rmux = 32'd0;
        endcase

        rvalid_d = accept;
        if (accept) begin
            rdata_d = rmux;
        end else begin
            rdata_d = rdata_q;
        end

`ifdef MMIO_INPUT_IRQ_EN
        if (wr_en && hit && (ofs == OFS_IRQMASK)) begin
            irqmask_d = wdata[N_BTN-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end
        irq_d = |(events_d & irqmask_q);
`endif
    end

    // Register state and read port; synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            btn_prev_q <= '0;
            events_q   <= '0;
            count_q    <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
`ifdef MMIO_INPUT_IRQ_EN
            irqmask_q  <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            btn_prev_q <= btn_prev_d;
            events_q   <= events_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef MMIO_INPUT_IRQ_EN
            irqmask_q  <= irqmask_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
`ifdef MMIO_INPUT_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
